// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-addressed DRAM load/store bridge.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } lsu_state_e;

    // Encoding 2'b11 has no narrower meaning, so it behaves as a full word.
    function automatic mem_size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dram_lsu_bridge_if.sv
// Request/response channel between the CPU memory stage and the DRAM bridge.
interface dram_lsu_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_lane_align.sv
// Lane steering between a 32-bit DRAM word and byte/half/word accesses:
// extract-and-extend for loads, lane merge for sub-word stores.
module mem_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word[{offset, 3'b000} +: 8];
    assign half_lane = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        load_data = word;
        merged    = wdata;
        case (size)
            BYTE: begin
                load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
                merged    = word;
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            HALF: begin
                load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
                merged    = word;
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dram_lsu_bridge.sv
// Byte-addressed load/store front end for the word-organised data DRAM.
// Sub-word stores are a read (ACCESS) followed by a write (WRITE) of the merged word.
module dram_lsu_bridge
    import lsu_pkg::*;
#(
    parameter int DRAM_AW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    dram_lsu_bridge_if.slave   bus,
    output logic [DRAM_AW-1:0] dram_a,
    output logic               dram_we,
    output logic [31:0]        dram_din,
    input  logic [31:0]        dram_spo
);

    lsu_state_e         state;
    logic [DRAM_AW+1:0] addr_q;
    mem_size_e          size_q;
    logic               unsigned_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [31:0]        merge_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic [31:0]        load_data;
    logic [31:0]        merged;
    mem_size_e          req_size;

    // Upper address bits alias the DRAM and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:DRAM_AW+2];

    assign req_size = decode_size(bus.req_size);

    mem_lane_align u_align (
        .word        (dram_spo),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Write strobes decode straight from state so an async reset kills them at once.
    assign dram_we  = (state == WRITE) || (state == ACCESS && we_q && size_q == WORD);
    assign dram_din = (state == WRITE) ? merge_q : (dram_we ? wdata_q : 32'h0);
    assign dram_a   = (state == ACCESS || state == WRITE) ? addr_q[DRAM_AW+1:2] : '0;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath holding registers are reset too, keeping outputs defined from reset.
            state        <= IDLE;
            addr_q       <= '0;
            size_q       <= BYTE;
            unsigned_q   <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q       <= bus.req_addr[DRAM_AW+1:0];
                        size_q       <= req_size;
                        unsigned_q   <= bus.req_unsigned;
                        we_q         <= bus.req_we;
                        wdata_q      <= bus.req_wdata;
                        resp_rdata_q <= 32'h0;
                        if (is_misaligned(req_size, bus.req_addr[1:0])) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else begin
                            resp_err_q <= 1'b0;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        resp_rdata_q <= load_data;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end else if (size_q == WORD) begin
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end else begin
                        merge_q <= merged;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_lsu_bridge.sv
// Scoreboard bench for dram_lsu_bridge: directed test-plan cases, reset abort,
// back-pressure and a randomised load/store mix against a reference memory.
module tb_dram_lsu_bridge;

    localparam int AW = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] dram_a;
    logic          dram_we;
    logic [31:0]   dram_din;
    logic [31:0]   dram_spo;

    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [31:0]   pre_d;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    resp_t       sb_q[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dram_lsu_bridge_if bus ();

    dram_lsu_bridge #(.DRAM_AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dram_a   (dram_a),
        .dram_we  (dram_we),
        .dram_din (dram_din),
        .dram_spo (dram_spo)
    );

    assign dram_spo = mem[dram_a];

    always @(posedge clk) begin
        if (dram_we)     mem[dram_a] <= dram_din;
        else if (pre_we) mem[pre_a]  <= pre_d;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err);
        resp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
        logic [31:0] v;
        v = w >> (a[1:0] * 8);
        if (sz == 2'b00) return u ? (v & 32'hFF)   : {{24{v[7]}}, v[7:0]};
        if (sz == 2'b01) return u ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] mask;
        mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << (a[1:0] * 8);
        return (w & ~mask) | ((d << (a[1:0] * 8)) & mask);
    endfunction

    // One request end to end; exp_we_lat=0 means no DRAM write may be seen.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input int exp_we_lat,
                          input logic [31:0] exp_din, input int hold);
        int          lat;
        int          we_n;
        int          we_lat;
        logic [31:0] we_din;
        logic [31:0] we_a;
        logic [31:0] held;
        resp_t       e;
        we_n = 0; we_lat = 0; we_din = 0; we_a = 0;
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.resp_ready   = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            if (dram_we) begin
                we_n++; we_lat = lat; we_din = dram_din; we_a = 32'(dram_a);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_seen", 32'(bus.resp_valid), 32'd1);
        chk("latency", lat, exp_lat);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rdata", bus.resp_rdata, e.rdata);
            chk("err", 32'(bus.resp_err), 32'(e.err));
        end else begin
            chk("sb_underflow", 32'd1, 32'(sb_q.size()));
        end
        chk("we_count", we_n, (exp_we_lat != 0) ? 1 : 0);
        if (exp_we_lat != 0) begin
            chk("we_cycle", we_lat, exp_we_lat);
            chk("we_din", we_din, exp_din);
            chk("we_addr", we_a, {16'h0, addr[AW+1:2]});
        end
        held = bus.resp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_rdata", bus.resp_rdata, held);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("resp_drop", 32'(bus.resp_valid), 32'd0);
        chk("ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, w, ed;
        logic [1:0]  sz;
        logic        we, u, err;
        int          lat, wl;

        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_dram_we", 32'(dram_we), 32'd0);
        chk("rst_dram_din", dram_din, 32'h0);
        chk("rst_dram_a", 32'(dram_a), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;

        poke(16'h0001, 32'h80FF_7F01);
        poke(16'h0002, 32'h1122_3344);

        push_exp(32'hFFFF_FF80, 1'b0); do_req(1'b0, 2'b00, 1'b0, 32'h7, 0, 2, 0, 0, 0);
        push_exp(32'h0000_0080, 1'b0); do_req(1'b0, 2'b00, 1'b1, 32'h7, 0, 2, 0, 0, 0);
        push_exp(32'hFFFF_80FF, 1'b0); do_req(1'b0, 2'b01, 1'b0, 32'h6, 0, 2, 0, 0, 0);
        push_exp(32'h80FF_7F01, 1'b0); do_req(1'b0, 2'b10, 1'b0, 32'h4, 0, 2, 0, 0, 0);
        push_exp(32'h80FF_7F01, 1'b0); do_req(1'b0, 2'b11, 1'b0, 32'h4, 0, 2, 0, 0, 0);
        push_exp(32'h80FF_7F01, 1'b0); do_req(1'b0, 2'b10, 1'b0, 32'h0004_0004, 0, 2, 0, 0, 0);

        push_exp(32'h0, 1'b0); do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFF_FFAB, 3, 2, 32'h1122_AB44, 0);
        chk("mem_w2", mem[2], 32'h1122_AB44);
        push_exp(32'h0, 1'b0); do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF, 0);
        push_exp(32'hDEAD_BEEF, 1'b0); do_req(1'b0, 2'b10, 1'b0, 32'hC, 0, 2, 0, 0, 0);

        push_exp(32'h0, 1'b1); do_req(1'b1, 2'b01, 1'b0, 32'h1, 32'h5555, 1, 0, 0, 0);
        push_exp(32'h0, 1'b1); do_req(1'b0, 2'b10, 1'b0, 32'h2, 0, 1, 0, 0, 0);
        chk("mem_w0_untouched_by_err", mem[0] === 32'hx ? 32'd0 : 32'd0, 32'd0 | (mem[1] ^ 32'h80FF_7F01));

        push_exp(32'h0000_7F01, 1'b0); do_req(1'b0, 2'b01, 1'b1, 32'h4, 0, 2, 0, 0, 5);

        for (int i = 0; i < 4; i++) poke(AW'(16 + i), $urandom);

        // Abort a sub-word store while it is writing back.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h41; bus.req_wdata = 32'h5A;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_we_high", 32'(dram_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we_drop", 32'(dram_we), 32'd0);
        chk("abort_din_zero", dram_din, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("abort_mem", mem[16], ref_mem[16]);

        for (int i = 0; i < 40; i++) begin
            a   = (32'(16 + $urandom_range(3)) << 2) | 32'($urandom_range(3)) | ($urandom & 32'hFFFC_0000);
            sz  = 2'($urandom_range(3));
            we  = 1'($urandom_range(1));
            u   = 1'($urandom_range(1));
            d   = $urandom;
            err = m_mis(sz, a);
            w   = ref_mem[a[AW+1:2]];
            ed  = sz[1] ? d : m_merge(w, a, sz, d);
            lat = err ? 1 : ((we && !sz[1]) ? 3 : 2);
            wl  = (err || !we) ? 0 : (sz[1] ? 1 : 2);
            push_exp((err || we) ? 32'h0 : m_load(w, a, sz, u), err);
            do_req(we, sz, u, a, d, lat, wl, ed, (i % 7 == 3) ? 2 : 0);
            if (we && !err) ref_mem[a[AW+1:2]] = ed;
        end
        for (int i = 0; i < 4; i++) chk("final_mem", mem[16 + i], ref_mem[16 + i]);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
